// File: rtl/roulette_game_ctrl.sv
// Game-round controller for the 8-LED roulette spinner: bet, spin, judge, pay out, game over.
// Optional SPIN watchdog enabled by defining SPIN_TIMEOUT_EN.
module roulette_game_ctrl #(
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned CREDIT_INIT = 10,
    parameter int unsigned BET_COST    = 1,
    parameter int unsigned PAYOUT      = 8,
    parameter int unsigned RESULT_HOLD = 100000000,
    parameter int unsigned TIMEOUT_CYC = 500000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_bet,
    input  logic [2:0]          bet_sel,
    input  logic                btn_spin,
    input  logic                btn_restart,
    input  logic                spin_done,
    input  logic [2:0]          spin_pos,
    output logic                spin_start,
    output logic [2:0]          bet_o,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          state_o,
    output logic                win,
    output logic                lose,
    output logic                err
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArmed  = 3'd1,
        StSpin   = 3'd2,
        StJudge  = 3'd3,
        StResult = 3'd4,
        StOver   = 3'd5
    } state_t;

    localparam int unsigned HOLD_W = $clog2(RESULT_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_HOLD - 1);

    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   COST_EXT   = (CREDIT_W + 1)'(BET_COST);
    localparam logic [CREDIT_W:0]   PAY_EXT    = (CREDIT_W + 1)'(PAYOUT);
    localparam logic [CREDIT_W-1:0] INIT_VAL   = CREDIT_W'(CREDIT_INIT);

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic [2:0]          bet_q;
    logic [2:0]          pos_q;
    logic                start_q;
    logic                win_q;
    logic                lose_q;
    logic [HOLD_W-1:0]   hold_cnt;

    // One extra bit of headroom so sums and comparisons never wrap.
    logic [CREDIT_W:0]   credit_ext;
    logic [CREDIT_W:0]   win_sum;
    logic [CREDIT_W:0]   charge_diff;
    logic [CREDIT_W-1:0] credit_win;
    logic [CREDIT_W-1:0] credit_charge;
    logic                can_bet;

    always_comb begin
        credit_ext    = {1'b0, credit_q};
        win_sum       = credit_ext + PAY_EXT;
        charge_diff   = credit_ext - COST_EXT;
        can_bet       = (credit_ext >= COST_EXT);
        credit_win    = (win_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0] : win_sum[CREDIT_W-1:0];
        credit_charge = charge_diff[CREDIT_W-1:0];
    end

`ifdef SPIN_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0]     wd_cnt;
    logic                err_q;
    logic [CREDIT_W:0]   refund_sum;
    logic [CREDIT_W-1:0] credit_refund;

    always_comb begin
        refund_sum    = credit_ext + COST_EXT;
        credit_refund = (refund_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0]
                                                  : refund_sum[CREDIT_W-1:0];
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            credit_q <= INIT_VAL;
            bet_q    <= '0;
            pos_q    <= '0;
            start_q  <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            hold_cnt <= '0;
`ifdef SPIN_TIMEOUT_EN
            wd_cnt   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
`ifdef SPIN_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    // A spin pressed together with the bet is dropped here.
                    if (btn_bet && can_bet) begin
                        credit_q <= credit_charge;
                        bet_q    <= bet_sel;
                        state    <= StArmed;
                    end
                end
                StArmed: begin
                    if (btn_bet) begin
                        bet_q <= bet_sel;
                    end
                    if (btn_spin) begin
                        start_q <= 1'b1;
                        state   <= StSpin;
`ifdef SPIN_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                StSpin: begin
                    if (spin_done) begin
                        pos_q <= spin_pos;
                        state <= StJudge;
                    end
`ifdef SPIN_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        credit_q <= credit_refund;
                        err_q    <= 1'b1;
                        state    <= StIdle;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                StJudge: begin
                    if (pos_q == bet_q) begin
                        credit_q <= credit_win;
                        win_q    <= 1'b1;
                    end else begin
                        lose_q <= 1'b1;
                    end
                    hold_cnt <= '0;
                    state    <= StResult;
                end
                StResult: begin
                    if (hold_cnt == HOLD_LAST) begin
                        win_q  <= 1'b0;
                        lose_q <= 1'b0;
                        state  <= can_bet ? StIdle : StOver;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                StOver: begin
                    if (btn_restart) begin
                        credit_q <= INIT_VAL;
                        bet_q    <= '0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign spin_start = start_q;
    assign bet_o      = bet_q;
    assign credit     = credit_q;
    assign state_o    = state;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_roulette_game_ctrl.sv
// Bench for roulette_game_ctrl: two instances (credit 10 and 250) share stimulus and are
// compared every cycle against a round-level model, plus hand-computed checkpoints.
module tb_roulette_game_ctrl;

    localparam int HOLD = 8;
    localparam int TMO  = 50;
    localparam int MAXC = 255;
    localparam int COST = 1;
    localparam int PAY  = 8;
`ifdef SPIN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_ARMED = 1, P_SPIN = 2, P_JUDGE = 3, P_RESULT = 4, P_OVER = 5;

    logic clk, rst;
    logic btn_bet, btn_spin, btn_restart, spin_done;
    logic [2:0] bet_sel, spin_pos;

    logic       a_start, a_win, a_lose, a_err;
    logic [2:0] a_bet, a_state;
    logic [7:0] a_credit;
    logic       b_start, b_win, b_lose, b_err;
    logic [2:0] b_bet, b_state;
    logic [7:0] b_credit;

    int n_checks = 0;
    int n_fail   = 0;

    roulette_game_ctrl #(.RESULT_HOLD(HOLD), .TIMEOUT_CYC(TMO)) u_dut_a (
        .clk(clk), .rst(rst), .btn_bet(btn_bet), .bet_sel(bet_sel), .btn_spin(btn_spin),
        .btn_restart(btn_restart), .spin_done(spin_done), .spin_pos(spin_pos),
        .spin_start(a_start), .bet_o(a_bet), .credit(a_credit), .state_o(a_state),
        .win(a_win), .lose(a_lose), .err(a_err)
    );

    roulette_game_ctrl #(.CREDIT_INIT(250), .RESULT_HOLD(HOLD), .TIMEOUT_CYC(TMO)) u_dut_b (
        .clk(clk), .rst(rst), .btn_bet(btn_bet), .bet_sel(bet_sel), .btn_spin(btn_spin),
        .btn_restart(btn_restart), .spin_done(spin_done), .spin_pos(spin_pos),
        .spin_start(b_start), .bet_o(b_bet), .credit(b_credit), .state_o(b_state),
        .win(b_win), .lose(b_lose), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-level model: phase, credit, countdown of remaining result cycles, spin age.
    typedef struct packed {
        int phase;
        int credit;
        int bet;
        int pos;
        int left;
        int age;
        bit start;
        bit win;
        bit lose;
        bit err;
    } mdl_t;

    function automatic int sat(int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic mdl_t mdl_reset(int init);
        mdl_t m;
        m = '0;
        m.credit = init;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int init, bit bb, int bs, bit bsp, bit br,
                                      bit sd, int sp);
        mdl_t n;
        n = m;
        n.start = 1'b0;
        n.err   = 1'b0;
        if (m.phase == P_IDLE) begin
            if (bb && m.credit >= COST) begin
                n.credit = m.credit - COST;
                n.bet    = bs;
                n.phase  = P_ARMED;
            end
        end else if (m.phase == P_ARMED) begin
            if (bb) n.bet = bs;
            if (bsp) begin
                n.phase = P_SPIN;
                n.start = 1'b1;
                n.age   = 0;
            end
        end else if (m.phase == P_SPIN) begin
            n.age = m.age + 1;
            if (sd) begin
                n.pos   = sp;
                n.phase = P_JUDGE;
            end else if (TMO_EN && n.age == TMO) begin
                n.credit = sat(m.credit + COST);
                n.err    = 1'b1;
                n.phase  = P_IDLE;
            end
        end else if (m.phase == P_JUDGE) begin
            if (m.pos == m.bet) begin
                n.credit = sat(m.credit + PAY);
                n.win    = 1'b1;
            end else begin
                n.lose = 1'b1;
            end
            n.left  = HOLD;
            n.phase = P_RESULT;
        end else if (m.phase == P_RESULT) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.win   = 1'b0;
                n.lose  = 1'b0;
                n.phase = (m.credit < COST) ? P_OVER : P_IDLE;
            end
        end else begin
            if (br) begin
                n.credit = init;
                n.bet    = 0;
                n.phase  = P_IDLE;
            end
        end
        return n;
    endfunction

    mdl_t ma, mb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mdl_reset(10);
            mb <= mdl_reset(250);
        end else begin
            ma <= mdl_step(ma, 10, btn_bet, int'(bet_sel), btn_spin, btn_restart, spin_done,
                           int'(spin_pos));
            mb <= mdl_step(mb, 250, btn_bet, int'(bet_sel), btn_spin, btn_restart, spin_done,
                           int'(spin_pos));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("a.state",  int'(a_state),  ma.phase);
            chk("a.credit", int'(a_credit), ma.credit);
            chk("a.bet",    int'(a_bet),    ma.bet);
            chk("a.start",  int'(a_start),  int'(ma.start));
            chk("a.win",    int'(a_win),    int'(ma.win));
            chk("a.lose",   int'(a_lose),   int'(ma.lose));
            chk("a.err",    int'(a_err),    int'(ma.err));
            chk("b.state",  int'(b_state),  mb.phase);
            chk("b.credit", int'(b_credit), mb.credit);
            chk("b.bet",    int'(b_bet),    mb.bet);
            chk("b.start",  int'(b_start),  int'(mb.start));
            chk("b.win",    int'(b_win),    int'(mb.win));
            chk("b.lose",   int'(b_lose),   int'(mb.lose));
            chk("b.err",    int'(b_err),    int'(mb.err));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_bet(input int sel);
        bet_sel = 3'(sel);
        btn_bet = 1'b1;
        tick(1);
        btn_bet = 1'b0;
    endtask

    task automatic press_spin();
        btn_spin = 1'b1;
        tick(1);
        btn_spin = 1'b0;
    endtask

    task automatic press_bet_spin(input int sel);
        bet_sel  = 3'(sel);
        btn_bet  = 1'b1;
        btn_spin = 1'b1;
        tick(1);
        btn_bet  = 1'b0;
        btn_spin = 1'b0;
    endtask

    task automatic press_done(input int pos);
        spin_pos  = 3'(pos);
        spin_done = 1'b1;
        tick(1);
        spin_done = 1'b0;
    endtask

    task automatic press_restart();
        btn_restart = 1'b1;
        tick(1);
        btn_restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        btn_bet = 1'b0; btn_spin = 1'b0; btn_restart = 1'b0; spin_done = 1'b0;
        bet_sel = 3'd0; spin_pos = 3'd0;
        tick(2);
        chk("rst.state",  int'(a_state),  0);
        chk("rst.credit", int'(a_credit), 10);
        chk("rst.credit_b", int'(b_credit), 250);
        chk("rst.start",  int'(a_start),  0);
        chk("rst.winlose", int'({a_win, a_lose, a_err}), 0);
        rst = 1'b0;
        tick(1);

        // Winning round; instance b saturates 249+8 at 255.
        press_bet(3);
        chk("bet.credit", int'(a_credit), 9);
        chk("bet.state",  int'(a_state),  1);
        press_spin();
        chk("spin.start", int'(a_start), 1);
        chk("spin.state", int'(a_state), 2);
        tick(2);
        press_done(3);
        chk("done.state", int'(a_state), 3);
        tick(1);
        chk("win.on",     int'(a_win),    1);
        chk("win.credit", int'(a_credit), 17);
        chk("win.sat",    int'(b_credit), 255);
        tick(7);
        chk("win.held",   int'(a_win), 1);
        tick(1);
        chk("win.off",    int'(a_win),   0);
        chk("win.idle",   int'(a_state), 0);

        // Losing rounds drain a to zero.
        for (int r = 0; r < 17; r++) begin
            press_bet(5);
            press_spin();
            tick(1);
            press_done(2);
            tick(1 + HOLD);
        end
        chk("over.state",  int'(a_state),  5);
        chk("over.credit", int'(a_credit), 0);
        chk("b.after",     int'(b_credit), 238);
        press_bet(1);
        chk("over.ignore", int'(a_state), 5);
        chk("over.bet",    int'(a_bet),   5);
        press_restart();
        chk("restart.state",  int'(a_state),  0);
        chk("restart.credit", int'(a_credit), 10);
        chk("restart.bet",    int'(a_bet),    0);

        // Spurious spin_done outside SPIN, then combined bet+spin presses.
        press_done(0);
        chk("spur.state", int'(a_state), 0);
        press_bet_spin(2);
        chk("combo.state",  int'(a_state),  1);
        chk("combo.start",  int'(a_start),  0);
        chk("combo.credit", int'(a_credit), 9);
        chk("combo.b_spin", int'(b_state),  2);
        press_bet_spin(6);
        chk("armed.combo.state", int'(a_state), 2);
        chk("armed.combo.bet",   int'(a_bet),   6);
        chk("armed.combo.start", int'(a_start), 1);
        tick(TMO - 1);
        chk("wd.before", int'(a_state), 2);
        tick(1);
`ifdef SPIN_TIMEOUT_EN
        chk("wd.err",    int'(a_err),    1);
        chk("wd.state",  int'(a_state),  0);
        chk("wd.credit", int'(a_credit), 10);
        tick(1);
        press_bet(4);
        press_spin();
`else
        chk("wd.err",    int'(a_err),    0);
        chk("wd.state",  int'(a_state),  2);
        chk("wd.credit", int'(a_credit), 9);
`endif

        // Reset in the middle of a spin.
        tick(3);
        rst = 1'b1;
        #1;
        chk("mrst.state",  int'(a_state),  0);
        chk("mrst.credit", int'(a_credit), 10);
        chk("mrst.bet",    int'(a_bet),    0);
        chk("mrst.outs",   int'({a_start, a_win, a_lose, a_err}), 0);
        tick(1);
        rst = 1'b0;
        tick(3);
        chk("post.credit", int'(b_credit), 250);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
